// File: rtl/poly_mem_streamer.sv
// -----------------------------------------------------------------------------
// poly_mem_streamer
//
// Reads polynomial coefficients out of the distributed coefficient RAM through
// its combinational read port. It reads addresses 0..deg and presents each word
// on a valid/ready stream, together with its index and a last flag. The
// consumer is the next SNTRUP757 arithmetic stage. This block never writes the
// RAM.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   start      sweep request, sampled only while idle
//   deg_in     last address to read, latched when start is accepted
//   busy       high whenever the controller is not idle
//   done       one-cycle pulse after the final beat handshake
//   mem_raddr  RAM read address (0 whenever no read is in progress)
//   mem_rdata  RAM read data, valid in the same cycle as mem_raddr
//   m_data     stream word
//   m_idx      coefficient index of m_data
//   m_last     set on the beat whose index equals the latched degree
//   m_valid    stream valid
//   m_ready    stream ready from the consumer
// -----------------------------------------------------------------------------
module poly_mem_streamer #(
  parameter int DATA_W = 26,
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] deg_in,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] m_data,
  output logic [ADDR_W-1:0] m_idx,
  output logic              m_last,
  output logic              m_valid,
  input  logic              m_ready
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   addr, addr_nxt;
  logic [ADDR_W-1:0]   deg_q, deg_nxt;
  logic [DATA_W-1:0]   data_nxt;
  logic [ADDR_W-1:0]   idx_nxt;
  logic                last_nxt;
  logic                valid_nxt;
  logic                load;
  logic                at_end;

  // The output register can take a new word when it is empty, or when the
  // word it holds is being consumed on this edge.
  assign load   = !m_valid || m_ready;
  // Sweep termination is an equality compare. A degree of 2047 therefore stops
  // at the top address and never wraps back to 0.
  assign at_end = (addr == deg_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      addr    <= '0;
      deg_q   <= '0;
      m_data  <= '0;
      m_idx   <= '0;
      m_last  <= 1'b0;
      m_valid <= 1'b0;
    end else begin
      state   <= state_nxt;
      addr    <= addr_nxt;
      deg_q   <= deg_nxt;
      m_data  <= data_nxt;
      m_idx   <= idx_nxt;
      m_last  <= last_nxt;
      m_valid <= valid_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    addr_nxt  = addr;
    deg_nxt   = deg_q;
    data_nxt  = m_data;
    idx_nxt   = m_idx;
    last_nxt  = m_last;
    valid_nxt = m_valid;
    busy      = (state != IDLE);
    done      = 1'b0;
    mem_raddr = '0;

    unique case (state)
      IDLE: begin
        if (start) begin
          deg_nxt   = deg_in;
          addr_nxt  = '0;
          state_nxt = RUN;
        end
      end

      RUN: begin
        mem_raddr = addr;
        if (load) begin
          data_nxt  = mem_rdata;
          idx_nxt   = addr;
          last_nxt  = at_end;
          valid_nxt = 1'b1;
          if (at_end) begin
            state_nxt = DRAIN;
          end else begin
            addr_nxt = addr + 1'b1;
          end
        end
      end

      // The last word is still in the output register. Wait for the consumer
      // to take it.
      DRAIN: begin
        if (m_ready) begin
          valid_nxt = 1'b0;
          last_nxt  = 1'b0;
          state_nxt = DONE;
        end
      end

      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_poly_mem_streamer.sv
module tb_poly_mem_streamer;

  localparam int DATA_W = 26;
  localparam int ADDR_W = 11;

  logic              clk;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] deg_in;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] mem_raddr;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] m_data;
  logic [ADDR_W-1:0] m_idx;
  logic              m_last;
  logic              m_valid;
  logic              m_ready;

  logic [DATA_W-1:0] ram [0:2047];

  int checks;
  int failures;

  poly_mem_streamer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .deg_in    (deg_in),
    .busy      (busy),
    .done      (done),
    .mem_raddr (mem_raddr),
    .mem_rdata (mem_rdata),
    .m_data    (m_data),
    .m_idx     (m_idx),
    .m_last    (m_last),
    .m_valid   (m_valid),
    .m_ready   (m_ready)
  );

  // Behavioural model of the combinational-read RAM
  assign mem_rdata = ram[mem_raddr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one sweep. mode 0: m_ready held at 1. mode 1: m_ready follows
  // 1,0,0,1 repeating. If restart is set, start is pulsed again mid-sweep
  // with deg_in=3.
  task automatic sweep(input int deg, input int mode, input bit restart);
    int exp_idx;
    int done_cnt;
    int last_hs;
    int limit;
    bit finished;
    exp_idx  = 0;
    done_cnt = 0;
    last_hs  = -10;
    finished = 0;
    limit    = (deg + 1) * 4 + 20;
    deg_in   = deg[ADDR_W-1:0];
    start    = 1'b1;
    m_ready  = (mode == 0);
    tick();
    start  = 1'b0;
    deg_in = deg[ADDR_W-1:0] ^ 11'h5;   // must not affect the running sweep
    for (int cyc = 0; cyc < limit && !finished; cyc++) begin
      if (restart && cyc == 3) begin
        start  = 1'b1;
        deg_in = 11'd3;
      end else begin
        start = 1'b0;
      end
      m_ready = (mode == 0) ? 1'b1 : ((cyc % 4) == 0 || (cyc % 4) == 3);
      #1;
      if (cyc == 0) begin
        check("first_cycle_valid_low", {31'd0, m_valid}, 32'd0);
        check("busy_after_start", {31'd0, busy}, 32'd1);
      end
      if (cyc == 1) check("first_valid_latency", {31'd0, m_valid}, 32'd1);
      if (m_valid) begin
        check("beat_idx", {21'd0, m_idx}, exp_idx);
        check("beat_data", {6'd0, m_data}, {6'd0, ram[exp_idx]});
        check("beat_last", {31'd0, m_last}, {31'd0, exp_idx == deg});
        if (m_ready) begin
          exp_idx++;
          last_hs = cyc;
        end
      end
      if (done) begin
        done_cnt++;
        check("done_timing", cyc, last_hs + 1);
        check("busy_during_done", {31'd0, busy}, 32'd1);
      end
      if (cyc > 0 && !busy) finished = 1;
      else tick();
    end
    start = 1'b0;
    check("sweep_finished", {31'd0, finished}, 32'd1);
    check("beat_count", exp_idx, deg + 1);
    check("done_count", done_cnt, 32'd1);
    if (mode == 0) check("consecutive_beats", last_hs, deg + 1);
    for (int k = 0; k < 3; k++) begin
      check("idle_valid_low", {31'd0, m_valid}, 32'd0);
      check("idle_raddr_zero", {21'd0, mem_raddr}, 32'd0);
      tick();
    end
  endtask

  initial begin
    int hs;
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    start    = 1'b0;
    deg_in   = '0;
    m_ready  = 1'b0;
    for (int i = 0; i < 2048; i++) ram[i] = 26'(i * 3);
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_valid", {31'd0, m_valid}, 32'd0);
    check("rst_last", {31'd0, m_last}, 32'd0);
    check("rst_data", {6'd0, m_data}, 32'd0);
    check("rst_idx", {21'd0, m_idx}, 32'd0);
    check("rst_raddr", {21'd0, mem_raddr}, 32'd0);
    tick();

    // 1: deg 7, continuous ready, data i*3
    sweep(7, 0, 1'b0);

    // 2: deg 0, all-ones word
    ram[0] = 26'h3FFFFFF;
    sweep(0, 0, 1'b0);
    ram[0] = 26'h0;

    // 3: deg 15 with stalls
    sweep(15, 1, 1'b0);

    // 4: full range, deg 2047
    sweep(2047, 0, 1'b0);

    // 5: second start while busy is ignored
    sweep(10, 0, 1'b1);

    // 6: reset mid-sweep while stalled
    deg_in  = 11'd9;
    start   = 1'b1;
    m_ready = 1'b1;
    tick();
    start = 1'b0;
    hs = 0;
    for (int cyc = 0; cyc < 20 && hs < 4; cyc++) begin
      if (m_valid && m_ready) hs++;
      tick();
    end
    check("rst_test_four_beats", hs, 32'd4);
    m_ready = 1'b0;
    tick();
    tick();
    check("stalled_valid_high", {31'd0, m_valid}, 32'd1);
    check("stalled_idx", {21'd0, m_idx}, 32'd4);
    rst = 1'b1;
    tick();
    check("midrst_valid", {31'd0, m_valid}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_last", {31'd0, m_last}, 32'd0);
    check("midrst_idx", {21'd0, m_idx}, 32'd0);
    check("midrst_data", {6'd0, m_data}, 32'd0);
    check("midrst_raddr", {21'd0, mem_raddr}, 32'd0);
    rst = 1'b0;
    tick();
    check("post_rst_no_done", {31'd0, done}, 32'd0);
    sweep(2, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
